// File: rtl/vga_bank_ram_if.sv
// Pixel-writer / scan-out bus for vga_bank_ram: one write port, one read port
// with valid, plus the sticky error flag and its clear.
interface vga_bank_ram_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
);
  logic              wr;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] dout;
  logic              rd_valid;
  logic              err;
  logic              err_clr;

  modport master (
    output wr, waddr, din, rd_en, raddr, err_clr,
    input  dout, rd_valid, err
  );

  modport slave (
    input  wr, waddr, din, rd_en, raddr, err_clr,
    output dout, rd_valid, err
  );
endinterface

// File: rtl/vga_bank_ram.sv
// Frame-buffer RAM built from N_BANKS block-RAM banks in one linear address
// space; write-first collision bypass, sticky range error, 1 or 2 cycle reads.
module vga_bank_ram #(
  parameter int DATA_W   = 12,
  parameter int BANK_AW  = 16,
  parameter int N_BANKS  = 5,
  parameter int ADDR_W   = 19,
  parameter int READ_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_bank_ram_if.slave  bus
);
  localparam int BANK_W  = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
  localparam int FIELD_W = ADDR_W - BANK_AW;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(N_BANKS) << BANK_AW;

  logic               w_in_range, r_in_range, collide, err_set, err_next;
  logic [FIELD_W-1:0] wfield, rfield;
  logic [BANK_W-1:0]  wbank, rbank;
  logic [BANK_AW-1:0] woff, roff;
  logic [DATA_W-1:0]  bank_q [N_BANKS];
  logic [DATA_W-1:0]  read_data;

  logic [BANK_W-1:0]  bank_reg;
  logic               in_range_reg, byp_reg, valid_reg, err_reg;
  logic [DATA_W-1:0]  byp_data_reg;

  assign w_in_range = {1'b0, bus.waddr} < LIMIT;
  assign r_in_range = {1'b0, bus.raddr} < LIMIT;
  assign wfield     = bus.waddr[ADDR_W-1:BANK_AW];
  assign rfield     = bus.raddr[ADDR_W-1:BANK_AW];
  assign wbank      = BANK_W'(wfield);
  assign rbank      = BANK_W'(rfield);
  assign woff       = bus.waddr[BANK_AW-1:0];
  assign roff       = bus.raddr[BANK_AW-1:0];

  // The bank read port is read-before-write, so a same-cycle hit is served from din.
  assign collide  = bus.wr && bus.rd_en && w_in_range && (bus.waddr == bus.raddr);
  assign err_set  = (bus.wr && !w_in_range) || (bus.rd_en && !r_in_range);
  assign err_next = err_set || (err_reg && !bus.err_clr);

  generate
    for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_bank
      logic [DATA_W-1:0] mem [2**BANK_AW];
      logic [DATA_W-1:0] q_reg;
      logic              we;

      assign we = bus.wr && w_in_range && (wbank == BANK_W'(gi));

      always_ff @(posedge clk) begin
        if (we)
          mem[woff] <= bus.din;
        if (bus.rd_en)
          q_reg <= mem[roff];
      end

      assign bank_q[gi] = q_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_reg     <= '0;
      in_range_reg <= 1'b0;
      byp_reg      <= 1'b0;
      byp_data_reg <= '0;
      valid_reg    <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      valid_reg <= bus.rd_en;
      err_reg   <= err_next;
      if (bus.rd_en) begin
        bank_reg     <= rbank;
        in_range_reg <= r_in_range;
        byp_reg      <= collide;
        byp_data_reg <= bus.din;
      end
    end
  end

  // Stage registers only move on rd_en, so this mux also holds dout between reads.
  always_comb begin
    read_data = '0;
    if (byp_reg)
      read_data = byp_data_reg;
    else if (in_range_reg)
      read_data = bank_q[bank_reg];
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] dout_reg;
      logic              valid2_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_reg   <= '0;
          valid2_reg <= 1'b0;
        end else begin
          valid2_reg <= valid_reg;
          if (valid_reg)
            dout_reg <= read_data;
        end
      end

      assign bus.dout     = dout_reg;
      assign bus.rd_valid = valid2_reg;
    end else begin : g_lat1
      assign bus.dout     = read_data;
      assign bus.rd_valid = valid_reg;
    end
  endgenerate

  assign bus.err = err_reg;
endmodule

// File: tb/tb_vga_bank_ram.sv
// Directed checks of vga_bank_ram: default 5x64K latency-1 build and a small
// 3x256 latency-2 build sharing one clock and reset.
module tb_vga_bank_ram;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  vga_bank_ram_if #(.ADDR_W(19), .DATA_W(12)) ia ();
  vga_bank_ram_if #(.ADDR_W(10), .DATA_W(12)) ib ();

  vga_bank_ram #(
    .DATA_W(12), .BANK_AW(16), .N_BANKS(5), .ADDR_W(19), .READ_LAT(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave)
  );

  vga_bank_ram #(
    .DATA_W(12), .BANK_AW(8), .N_BANKS(3), .ADDR_W(10), .READ_LAT(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [18:0] addr, input logic [11:0] data);
    ia.wr = 1'b1; ia.waddr = addr; ia.din = data;
    tick();
    ia.wr = 1'b0;
  endtask

  task automatic rd_a(input string tag, input logic [18:0] addr, input logic [11:0] exp);
    ia.rd_en = 1'b1; ia.raddr = addr;
    tick();
    ia.rd_en = 1'b0;
    check({tag, "_dout"}, 32'(ia.dout), 32'(exp));
    check({tag, "_valid"}, 32'(ia.rd_valid), 32'd1);
  endtask

  task automatic wr_b(input logic [9:0] addr, input logic [11:0] data);
    ib.wr = 1'b1; ib.waddr = addr; ib.din = data;
    tick();
    ib.wr = 1'b0;
  endtask

  task automatic rd_b(input string tag, input logic [9:0] addr, input logic [11:0] exp);
    ib.rd_en = 1'b1; ib.raddr = addr;
    tick();
    ib.rd_en = 1'b0;
    check({tag, "_early"}, 32'(ib.rd_valid), 32'd0);
    tick();
    check({tag, "_dout"}, 32'(ib.dout), 32'(exp));
    check({tag, "_valid"}, 32'(ib.rd_valid), 32'd1);
  endtask

  logic [18:0] a_addr [4];
  logic [11:0] a_data [4];
  logic [9:0]  b_addr [4];
  logic [11:0] b_data [4];

  initial begin
    checks = 0;
    errors = 0;
    a_addr = '{19'h0FFFF, 19'h10000, 19'h3FFFF, 19'h40000};
    a_data = '{12'h101, 12'h202, 12'h303, 12'h404};
    b_addr = '{10'h0FF, 10'h100, 10'h1FF, 10'h200};
    b_data = '{12'h011, 12'h022, 12'h033, 12'h044};

    rst_n = 1'b0;
    ia.wr = 1'b0; ia.waddr = '0; ia.din = '0; ia.rd_en = 1'b0; ia.raddr = '0; ia.err_clr = 1'b0;
    ib.wr = 1'b0; ib.waddr = '0; ib.din = '0; ib.rd_en = 1'b0; ib.raddr = '0; ib.err_clr = 1'b0;
    repeat (3) tick();
    check("rst_a_dout", 32'(ia.dout), 32'd0);
    check("rst_a_valid", 32'(ia.rd_valid), 32'd0);
    check("rst_a_err", 32'(ia.err), 32'd0);
    check("rst_b_dout", 32'(ib.dout), 32'd0);
    check("rst_b_valid", 32'(ib.rd_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic write/read at both ends of the address space
    wr_a(19'h00000, 12'hABC);
    wr_a(19'h4FFFF, 12'h123);
    rd_a("a_rd0", 19'h00000, 12'hABC);
    rd_a("a_rd4ffff", 19'h4FFFF, 12'h123);
    check("a_err_clean", 32'(ia.err), 32'd0);
    tick();
    check("a_idle_valid", 32'(ia.rd_valid), 32'd0);
    check("a_idle_hold", 32'(ia.dout), 32'h123);

    // Bank boundaries, back-to-back reads
    for (int i = 0; i < 4; i++) wr_a(a_addr[i], a_data[i]);
    for (int i = 0; i < 4; i++) begin
      ia.rd_en = 1'b1; ia.raddr = a_addr[i];
      tick();
      check($sformatf("a_b2b%0d_dout", i), 32'(ia.dout), 32'(a_data[i]));
      check($sformatf("a_b2b%0d_valid", i), 32'(ia.rd_valid), 32'd1);
    end
    ia.rd_en = 1'b0;
    tick();
    check("a_b2b_end_valid", 32'(ia.rd_valid), 32'd0);
    check("a_b2b_end_hold", 32'(ia.dout), 32'h404);

    // Same-cycle collision is write-first
    wr_a(19'h20000, 12'h111);
    ia.wr = 1'b1; ia.waddr = 19'h20000; ia.din = 12'h777;
    ia.rd_en = 1'b1; ia.raddr = 19'h20000;
    tick();
    ia.wr = 1'b0; ia.rd_en = 1'b0;
    check("a_coll_dout", 32'(ia.dout), 32'h777);
    check("a_coll_valid", 32'(ia.rd_valid), 32'd1);
    rd_a("a_coll_after", 19'h20000, 12'h777);

    // Out of range
    wr_a(19'h50000, 12'h555);
    check("a_oor_wr_err", 32'(ia.err), 32'd1);
    rd_a("a_oor_rd", 19'h50000, 12'h000);
    check("a_oor_rd_err", 32'(ia.err), 32'd1);
    rd_a("a_oor_alias0", 19'h00000, 12'hABC);
    ia.err_clr = 1'b1; ia.rd_en = 1'b1; ia.raddr = 19'h50000;
    tick();
    ia.rd_en = 1'b0;
    check("a_clr_vs_set", 32'(ia.err), 32'd1);
    tick();
    ia.err_clr = 1'b0;
    check("a_clr_alone", 32'(ia.err), 32'd0);

    // Second build: latency 2, 3 banks of 256
    wr_b(10'h000, 12'hABC);
    wr_b(10'h2FF, 12'h123);
    rd_b("b_rd0", 10'h000, 12'hABC);
    rd_b("b_rd2ff", 10'h2FF, 12'h123);
    check("b_err_clean", 32'(ib.err), 32'd0);
    for (int i = 0; i < 4; i++) wr_b(b_addr[i], b_data[i]);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        ib.rd_en = 1'b1; ib.raddr = b_addr[i];
      end else begin
        ib.rd_en = 1'b0;
      end
      tick();
      if (i == 0) begin
        check("b_b2b_lat", 32'(ib.rd_valid), 32'd0);
      end else begin
        check($sformatf("b_b2b%0d_dout", i - 1), 32'(ib.dout), 32'(b_data[i-1]));
        check($sformatf("b_b2b%0d_valid", i - 1), 32'(ib.rd_valid), 32'd1);
      end
    end
    tick();
    check("b_b2b_end_valid", 32'(ib.rd_valid), 32'd0);
    wr_b(10'h300, 12'h555);
    check("b_oor_wr_err", 32'(ib.err), 32'd1);
    rd_b("b_oor_rd", 10'h300, 12'h000);
    rd_b("b_oor_alias0", 10'h000, 12'hABC);

    // Reset in the middle of reads
    ia.rd_en = 1'b1; ia.raddr = 19'h00000;
    ib.rd_en = 1'b1; ib.raddr = 10'h0FF;
    tick();
    ia.rd_en = 1'b0; ib.rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("a_mid_rst_valid", 32'(ia.rd_valid), 32'd0);
    check("a_mid_rst_dout", 32'(ia.dout), 32'd0);
    check("a_mid_rst_err", 32'(ia.err), 32'd0);
    tick();
    check("b_mid_rst_valid", 32'(ib.rd_valid), 32'd0);
    check("b_mid_rst_dout", 32'(ib.dout), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("b_post_rst_valid", 32'(ib.rd_valid), 32'd0);
    rd_a("a_post_rst", 19'h4FFFF, 12'h123);
    rd_a("a_post_rst_bnd", 19'h10000, 12'h202);
    rd_b("b_post_rst", 10'h1FF, 12'h033);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
